// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: funct3 codes,
// clear-sequencer states, lane count and the misalignment predicate.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned NLANES = 4;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    // Half accesses need an even address, word accesses a multiple of 4.
    // LHU only exists as a load, so it counts as a half access for loads only.
    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo,
        input logic       is_store
    );
        logic half;
        logic word;
        half = (f3 == F3_H) || (!is_store && (f3 == F3_HU));
        word = (f3 == F3_W);
        return (half && lo[0]) || (word && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the byte/half lane from a memory word and extends it.
// Ports: word_i (raw word), lane_i (Address[1:0]), func3_i, data_o (result).
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = word_i[{lane_i, 3'b000} +: 8];
        // Half lane uses Address[1] only; bit 0 is truncated.
        h      = lane_i[1] ? word_i[31:16] : word_i[15:0];
        data_o = '0;
        case (func3_i)
            F3_B:    data_o = {{24{b[7]}}, b};
            F3_H:    data_o = {{16{h[15]}}, h};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'b0, b};
            F3_HU:   data_o = {16'b0, h};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with post-reset clear, pipelined reads and
// optional misalignment rejection (define DMEM_MISALIGN_CHECK_EN).
// Ports: Clock, Reset (sync, active high), Read/Write/Func3/Address/
// Write_data request; Read_data/Read_valid load result; Busy during clear;
// Misaligned strobe for rejected accesses.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Read,
    input  logic        Write,
    input  logic [2:0]  Func3,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        Read_valid,
    output logic        Busy,
    output logic        Misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int L  = READ_LATENCY;

    state_e              state_q;
    logic [AW-1:0]       cnt_q;
    logic [31:0]         mem [DEPTH];

    logic                busy;
    logic [AW-1:0]       idx;
    logic [1:0]          lo;
    logic                acc_wr;
    logic                acc_rd;
    logic                mis_req;
    logic [NLANES-1:0]   be_d;
    logic [31:0]         wd_d;

    logic [L-1:0]        vld_q;
    logic [L-1:0]        mis_q;
    logic [31:0]         wrd_q [L];
    logic [2:0]          f3_q  [L];
    logic [1:0]          lo_q  [L];
    logic                st_mis_q;
    logic [31:0]         last_q;
    logic [31:0]         aligned;
    logic [31:0]         rdata_d;

    logic                unused_addr;
    assign unused_addr = ^Address[31:AW+2];

    // Reset itself counts as busy so nothing is accepted in a reset cycle.
    assign busy   = Reset || (state_q == INIT);
    assign Busy   = busy;
    assign idx    = Address[AW+1:2];
    assign lo     = Address[1:0];
    assign acc_wr = !busy && Write;
    assign acc_rd = !busy && Read && !Write;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_req = misaligned(Func3, lo, Write);
`else
    assign mis_req = 1'b0;
`endif

    always_comb begin
        be_d = '0;
        wd_d = Write_data;
        case (Func3)
            F3_B: begin
                be_d = 4'b0001 << lo;
                wd_d = {4{Write_data[7:0]}};
            end
            F3_H: begin
                be_d = lo[1] ? 4'b1100 : 4'b0011;
                wd_d = {2{Write_data[15:0]}};
            end
            F3_W:    be_d = 4'b1111;
            default: be_d = '0;
        endcase
        if (!acc_wr || mis_req) begin
            be_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_q <= READY;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset && (state_q == INIT)) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NLANES; i++) begin
                if (be_d[i]) begin
                    mem[idx][8*i +: 8] <= wd_d[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            vld_q    <= '0;
            st_mis_q <= 1'b0;
            last_q   <= '0;
        end else begin
            vld_q[0] <= acc_rd;
            for (int i = 1; i < L; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            st_mis_q <= acc_wr && mis_req;
            last_q   <= rdata_d;
        end
    end

    always_ff @(posedge Clock) begin
        wrd_q[0] <= mem[idx];
        f3_q[0]  <= Func3;
        lo_q[0]  <= lo;
        mis_q[0] <= mis_req;
        for (int i = 1; i < L; i++) begin
            wrd_q[i] <= wrd_q[i-1];
            f3_q[i]  <= f3_q[i-1];
            lo_q[i]  <= lo_q[i-1];
            mis_q[i] <= mis_q[i-1];
        end
    end

    dmem_load_align u_align (
        .word_i  (wrd_q[L-1]),
        .lane_i  (lo_q[L-1]),
        .func3_i (f3_q[L-1]),
        .data_o  (aligned)
    );

    // Output holds the last delivered value between strobes.
    always_comb begin
        rdata_d = last_q;
        if (vld_q[L-1]) begin
            rdata_d = mis_q[L-1] ? '0 : aligned;
        end
    end

    assign Read_data  = rdata_d;
    assign Read_valid = vld_q[L-1];
    assign Misaligned = st_mis_q || (vld_q[L-1] && mis_q[L-1]);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane, DEPTH=16, READ_LATENCY=3.
// Expectations follow DMEM_MISALIGN_CHECK_EN when it is defined.
module tb_dmem_bytelane;

    localparam int DEPTH = 16;
    localparam int RL    = 3;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;
    localparam logic [2:0] XX = 3'b011;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Read = 1'b0;
    logic        Write = 1'b0;
    logic [2:0]  Func3 = 3'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        Read_valid;
    logic        Busy;
    logic        Misaligned;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] d;
    logic        m;

    dmem_bytelane #(
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Read       (Read),
        .Write      (Write),
        .Func3      (Func3),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .Read_valid (Read_valid),
        .Busy       (Busy),
        .Misaligned (Misaligned)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        Write      = 1'b1;
        Func3      = f3;
        Address    = a;
        Write_data = wd;
        tick();
        Write = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] a,
                        output logic [31:0] rd, output logic mis);
        Read    = 1'b1;
        Func3   = f3;
        Address = a;
        tick();
        Read = 1'b0;
        for (int i = 1; i < RL; i++) begin
            check("early_valid", {31'b0, Read_valid}, 32'd0);
            tick();
        end
        check("valid", {31'b0, Read_valid}, 32'd1);
        rd  = Read_data;
        mis = Misaligned;
    endtask

    initial begin
        tick();
        check("rst_busy",  {31'b0, Busy},       32'd1);
        check("rst_valid", {31'b0, Read_valid}, 32'd0);
        check("rst_data",  Read_data,           32'd0);
        check("rst_mis",   {31'b0, Misaligned}, 32'd0);

        // Clear sequence: exactly DEPTH busy cycles, reads dropped.
        Reset   = 1'b0;
        Read    = 1'b1;
        Func3   = W;
        Address = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            check("busy_clear", {31'b0, Busy},       32'd1);
            check("busy_valid", {31'b0, Read_valid}, 32'd0);
            tick();
        end
        Read = 1'b0;
        check("busy_done", {31'b0, Busy}, 32'd0);
        for (int i = 0; i < RL; i++) begin
            check("drop_valid", {31'b0, Read_valid}, 32'd0);
            tick();
        end

        load(W, 32'h8, d, m);   check("clr_w2",  d, 32'h0);
        load(W, 32'h3C, d, m);  check("clr_w15", d, 32'h0);

        store(W, 32'h0, 32'h8899AABB);
        load(B,  32'h0, d, m);  check("lb0",  d, 32'hFFFFFFBB);
        load(BU, 32'h1, d, m);  check("lbu1", d, 32'h000000AA);
        load(H,  32'h2, d, m);  check("lh2",  d, 32'hFFFF8899);
        load(HU, 32'h2, d, m);  check("lhu2", d, 32'h00008899);

        store(B, 32'h3, 32'hFFFFFF5A);
        load(W, 32'h0, d, m);   check("sb_lw",   d, 32'h5A99AABB);
        load(W, 32'h40, d, m);  check("wrap_lw", d, 32'h5A99AABB);

        store(XX, 32'h0, 32'hDEADDEAD);
        load(W, 32'h0, d, m);   check("f3x_nowr", d, 32'h5A99AABB);
        load(XX, 32'h0, d, m);  check("f3x_ld",   d, 32'h0);

        // Three back-to-back reads.
        store(W, 32'h10, 32'hAAAA0001);
        store(W, 32'h14, 32'hBBBB0002);
        store(W, 32'h18, 32'hCCCC0003);
        Read    = 1'b1;
        Func3   = W;
        Address = 32'h10;
        tick();
        check("pipe_v1", {31'b0, Read_valid}, 32'd0);
        Address = 32'h14;
        tick();
        check("pipe_v2", {31'b0, Read_valid}, 32'd0);
        Address = 32'h18;
        tick();
        Read = 1'b0;
        check("pipe_v3", {31'b0, Read_valid}, 32'd1);
        check("pipe_d0", Read_data, 32'hAAAA0001);
        tick();
        check("pipe_v4", {31'b0, Read_valid}, 32'd1);
        check("pipe_d1", Read_data, 32'hBBBB0002);
        tick();
        check("pipe_v5", {31'b0, Read_valid}, 32'd1);
        check("pipe_d2", Read_data, 32'hCCCC0003);
        tick();
        check("pipe_end",  {31'b0, Read_valid}, 32'd0);
        check("pipe_hold", Read_data, 32'hCCCC0003);

        // Read and Write together: store wins, no strobe.
        Read       = 1'b1;
        Write      = 1'b1;
        Func3      = W;
        Address    = 32'h4;
        Write_data = 32'h00001234;
        tick();
        Read  = 1'b0;
        Write = 1'b0;
        for (int i = 0; i < RL + 1; i++) begin
            check("rw_novalid", {31'b0, Read_valid}, 32'd0);
            tick();
        end
        load(W, 32'h4, d, m);   check("rw_lw", d, 32'h00001234);

        store(H, 32'h6, 32'h7777C0DE);
        load(W, 32'h4, d, m);   check("sh_lw", d, 32'hC0DE1234);

        // Misaligned accesses.
        store(W, 32'h0, 32'hCAFEBEEF);
        load(H, 32'h1, d, m);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_lh_d", d, 32'h0);
        check("mis_lh_m", {31'b0, m}, 32'd1);
`else
        check("mis_lh_d", d, 32'hFFFFBEEF);
        check("mis_lh_m", {31'b0, m}, 32'd0);
`endif
        store(W, 32'h2, 32'h12345678);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("mis_sw_m", {31'b0, Misaligned}, 32'd1);
        tick();
        load(W, 32'h0, d, m);   check("mis_sw_d", d, 32'hCAFEBEEF);
`else
        check("mis_sw_m", {31'b0, Misaligned}, 32'd0);
        tick();
        load(W, 32'h0, d, m);   check("mis_sw_d", d, 32'h12345678);
`endif

        // Reset mid-stream flushes in-flight reads and restarts the clear.
        Read    = 1'b1;
        Func3   = W;
        Address = 32'h10;
        tick();
        Address = 32'h14;
        tick();
        Read  = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mrst_data", Read_data, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            check("mrst_busy",  {31'b0, Busy},       32'd1);
            check("mrst_valid", {31'b0, Read_valid}, 32'd0);
            tick();
        end
        check("mrst_done", {31'b0, Busy}, 32'd0);
        load(W, 32'h10, d, m);  check("mrst_clr", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised byte-lane data memory for the RV32IM pipeline's MEM stage, successor to the single-word data memory. It provides RV32 byte/half/word stores with per-lane write enables, sign- or zero-extended loads, a configurable registered read latency with a valid strobe, and a post-reset clear sequencer that zeroes the whole array while holding `Busy`. Optional misalignment detection reports illegal half/word accesses to the trap logic.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 4; `AW = $clog2(DEPTH)`.
- `READ_LATENCY`, 1: cycles from read acceptance to `Read_valid`; legal 1..3.
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Read` in 1: load request.
- `Write` in 1: store request.
- `Func3` in 3: RV32 funct3 (size/sign).
- `Address` in 32: byte address.
- `Write_data` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `Read_data` out 32: extended load result.
- `Read_valid` out 1: one-cycle strobe qualifying `Read_data`.
- `Busy` out 1: clear sequence running; requests ignored.
- `Misaligned` out 1: one-cycle strobe for a rejected access (see Configuration).

## Operation
- FSM states `INIT`, `READY`. `Reset` → `INIT`, clear counter = 0. In `INIT`, write 0 to word `counter` each cycle and increment. After word DEPTH-1, go to `READY`. `Busy` = (state == `INIT`).
- Acceptance: cycle where `Busy`=0 and (`Read` | `Write`). While `Busy`=1, requests are dropped, not queued.
- Word index = `Address[AW+1:2]`. Upper bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
- Stores: `000` SB writes lane `Address[1:0]` from `Write_data[7:0]`. `001` SH writes lanes {`Address[1]`,0} and {`Address[1]`,1} from `Write_data[15:0]`. `010` SW writes all lanes. Any other funct3: no write, no error.
- Loads: `000` LB and `001` LH sign-extend. `100` LBU and `101` LHU zero-extend. `010` LW returns the full word. `011`/`110`/`111` return 0 but still strobe `Read_valid`.
- `Read` and `Write` both high: the store is performed and the read is discarded (no `Read_valid`).
- Reads are fully pipelined, one per cycle. The in-flight pipeline holds data plus `Func3`/`Address[1:0]`.
- Reset values: `Read_data` = 0, `Read_valid` = 0, `Misaligned` = 0, `Busy` = 1.

## Timing
- Array read samples at the acceptance edge. `Read_data`/`Read_valid` appear exactly `READ_LATENCY` cycles after the acceptance cycle. `Read_data` holds its last value when `Read_valid` = 0.
- A store is committed at the acceptance edge. A read accepted in the next cycle to the same word returns the new data. A read and a store accepted in the same cycle are not both possible (store wins).
- `Busy` is high during every `Reset` cycle and for exactly DEPTH cycles after `Reset` falls. The first acceptance is possible in cycle DEPTH+1.
- Reset mid-operation (in `READY` or `INIT`): in-flight reads are flushed with no `Read_valid`, and the clear restarts from word 0. Array contents are undefined until the clear completes.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - A half access with `Address[0]`=1, or a word access with `Address[1:0]`≠0, is rejected.
  - A rejected store writes nothing. A rejected load returns 0 with `Read_valid`.
  - `Misaligned` pulses high in the same cycle a rejected load's `Read_valid` would be, and one cycle after acceptance for a rejected store.
- Undefined: `Misaligned` is tied 0. Low address bits are truncated to natural alignment: half uses `Address[1]` only, word ignores `Address[1:0]`.

## Structure
- Package `dmem_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), the FSM state enum, and the byte-lane enable width constant.
- Sub-module `dmem_load_align` (combinational): takes a word, `Address[1:0]` and `Func3` and returns the selected lane, sign/zero-extended. It is instantiated at the pipeline output.
- The top level holds the FSM, clear counter, byte-enabled array and latency pipeline.

## Test plan
- Reset 1 cycle, DEPTH=16 → `Busy` high for 16 cycles after release. `Read` during `Busy` gives no `Read_valid`. LW from any word after that returns 0.
- SW 0x8899AABB @0x0, then LB @0x0 → 0xFFFFFFBB; LBU @0x1 → 0x000000AA; LH @0x2 → 0xFFFF8899; LHU @0x2 → 0x00008899.
- SB 0x5A @0x3 over 0x8899AABB, then LW @0x0 next cycle → 0x5A99AABB; LW @0x40 with DEPTH=16 → same word (wrap).
- READ_LATENCY=3: reads in three consecutive cycles → three consecutive `Read_valid` strobes starting 3 cycles after the first read, in order. Asserting `Reset` mid-stream produces no further strobes.
- With `DMEM_MISALIGN_CHECK_EN`: SW @0x2 → `Misaligned` pulse and memory unchanged; LH @0x1 → `Read_data` 0 with `Read_valid` and `Misaligned` in the same cycle. Without the macro: LH @0x1 returns the half at 0x0.
- `Read`=`Write`=1, SW 0x1234 @0x4 → no `Read_valid`. A following LW @0x4 → 0x00001234.
